// File: rtl/ec233_pkg.sv
// Shared constants, state encoding and combinational GF(2^233) helpers for the
// sect233r1 point-validation stage.
package ec233_pkg;

    localparam int unsigned M  = 233;
    localparam int unsigned FK = 74;

    // f(x) = x^233 + x^74 + 1
    localparam logic [M:0] F = {1'b1, 158'b0, 1'b1, 73'b0, 1'b1};

    localparam logic [M-1:0] B = 233'h066647EDE6C332C7F8C0923BB58213B333B20E9CE4281FE115F7D8F90AD;

    localparam logic [1:0] ERR_OK           = 2'd0;
    localparam logic [1:0] ERR_X_ZERO       = 2'd1;
    localparam logic [1:0] ERR_NOT_ON_CURVE = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        SQR,
        MUL1,
        MUL2,
        CMP,
        FIN
    } state_t;

    function automatic logic [M-1:0] gf233_add(input logic [M-1:0] a, input logic [M-1:0] b);
        return a ^ b;
    endfunction

    // Squaring spreads the bits, then folds every term of degree >= M back by f.
    function automatic logic [M-1:0] gf233_sqr(input logic [M-1:0] a);
        logic [2*M-2:0] t;
        t = '0;
        for (int i = 0; i < M; i++) begin
            t[2*i] = a[i];
        end
        for (int i = 2*M-2; i >= M; i--) begin
            if (t[i]) begin
                t[i-M]    = ~t[i-M];
                t[i-M+FK] = ~t[i-M+FK];
            end
        end
        return t[M-1:0];
    endfunction

endpackage

// File: rtl/gf233_mul_digit.sv
// MSB-first digit-serial GF(2^233) multiplier; the first digit is consumed on the
// start edge so done pulses exactly L cycles after the start cycle.
module gf233_mul_digit
    import ec233_pkg::*;
#(
    parameter int unsigned D = 8
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] c,
    output logic         done
);

    localparam int unsigned L  = (M + D - 1) / D;
    localparam int unsigned BW = L * D;
    localparam int unsigned CW = $clog2(L + 1);

    logic [M-1:0]  r_a;
    logic [M-1:0]  r_acc;
    logic [BW-1:0] r_b;
    logic [CW-1:0] r_cnt;
    logic          r_run;
    logic          r_done;

    logic [BW-1:0] w_b_pad;
    logic [M-1:0]  w_a;
    logic [M-1:0]  w_acc_in;
    logic [M-1:0]  w_acc_nxt;
    logic [D-1:0]  w_dig;

    function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? F[M-1:0] : '0);
    endfunction

    // One Horner step per cycle: acc = acc * x^D + a * digit, reduced bit by bit.
    always_comb begin
        w_b_pad   = BW'(b);
        w_a       = start ? a  : r_a;
        w_acc_in  = start ? '0 : r_acc;
        w_dig     = start ? w_b_pad[BW-1 -: D] : r_b[BW-1 -: D];
        w_acc_nxt = w_acc_in;
        for (int j = D - 1; j >= 0; j--) begin
            w_acc_nxt = xtime(w_acc_nxt) ^ (w_dig[j] ? w_a : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_acc  <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_a   <= a;
                r_b   <= w_b_pad << D;
                r_acc <= w_acc_nxt;
                r_cnt <= CW'(L - 1);
                r_run <= 1'b1;
            end else if (r_run) begin
                r_b   <= r_b << D;
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign c    = r_acc;
    assign done = r_done;

endmodule

// File: rtl/ec_point_validate_233.sv
// Checks that an affine point lies on sect233r1 (y^2 + xy = x^3 + x^2 + b) and is
// not the order-2 point, forwarding registered copies of accepted points.
module ec_point_validate_233
    import ec233_pkg::*;
#(
    parameter int unsigned D = 8
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M-1:0] Px,
    input  logic [M-1:0] Py,
    output logic         busy,
    output logic         done,
    output logic         valid,
    output logic [1:0]   err,
    output logic [M-1:0] Qx,
    output logic [M-1:0] Qy
);

    state_t       r_state;
    state_t       w_next;

    logic [M-1:0] r_xr;
    logic [M-1:0] r_yr;
    logic [M-1:0] r_s;
    logic [M-1:0] r_y2;
    logic [M-1:0] r_t;
    logic [M-1:0] r_u;
    logic         r_issued;
    logic         r_res_ok;
    logic [1:0]   r_res_err;

    logic         r_busy;
    logic         r_done;
    logic         r_valid;
    logic [1:0]   r_err;
    logic [M-1:0] r_qx;
    logic [M-1:0] r_qy;

    logic         w_accept;
    logic         w_mul_start;
    logic         w_mul_done;
    logic [M-1:0] w_mul_a;
    logic [M-1:0] w_mul_b;
    logic [M-1:0] w_mul_c;
    logic         w_xr_zero;
    logic         w_on_curve;

    assign w_xr_zero  = (r_xr == '0);
    assign w_on_curve = (gf233_add(r_y2, r_t) == gf233_add(r_u, B));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // x*y is launched from SQR so it overlaps the squaring; x^2*(x+1) launches on MUL2 entry.
    // FIN lasts two cycles so a start coinciding with done is still ignored.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_mul_start = 1'b0;
        w_mul_a     = r_xr;
        w_mul_b     = r_yr;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = SQR;
                end
            end
            SQR: begin
                w_mul_start = !w_xr_zero;
                w_next      = w_xr_zero ? FIN : MUL1;
            end
            MUL1: begin
                if (w_mul_done) w_next = MUL2;
            end
            MUL2: begin
                w_mul_a     = r_s;
                w_mul_b     = gf233_add(r_xr, M'(1));
                w_mul_start = !r_issued;
                if (w_mul_done) w_next = CMP;
            end
            CMP: w_next = FIN;
            FIN: begin
                if (r_done) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xr      <= '0;
            r_yr      <= '0;
            r_s       <= '0;
            r_y2      <= '0;
            r_t       <= '0;
            r_u       <= '0;
            r_issued  <= 1'b0;
            r_res_ok  <= 1'b0;
            r_res_err <= ERR_OK;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_err     <= ERR_OK;
            r_qx      <= '0;
            r_qy      <= '0;
        end else begin
            r_done <= 1'b0;

            if (w_mul_start)     r_issued <= 1'b1;
            else if (w_mul_done) r_issued <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_xr    <= Px;
                        r_yr    <= Py;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                        r_err   <= ERR_OK;
                        r_qx    <= '0;
                        r_qy    <= '0;
                    end
                end
                SQR: begin
                    r_s  <= gf233_sqr(r_xr);
                    r_y2 <= gf233_sqr(r_yr);
                    if (w_xr_zero) begin
                        r_res_ok  <= 1'b0;
                        r_res_err <= ERR_X_ZERO;
                    end
                end
                MUL1: begin
                    if (w_mul_done) r_t <= w_mul_c;
                end
                MUL2: begin
                    if (w_mul_done) r_u <= w_mul_c;
                end
                CMP: begin
                    r_res_ok  <= w_on_curve;
                    r_res_err <= w_on_curve ? ERR_OK : ERR_NOT_ON_CURVE;
                end
                FIN: begin
                    if (!r_done) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_valid <= r_res_ok;
                        r_err   <= r_res_err;
                        r_qx    <= r_res_ok ? r_xr : '0;
                        r_qy    <= r_res_ok ? r_yr : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    gf233_mul_digit #(
        .D (D)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_mul_start),
        .a     (w_mul_a),
        .b     (w_mul_b),
        .c     (w_mul_c),
        .done  (w_mul_done)
    );

    assign busy  = r_busy;
    assign done  = r_done;
    assign valid = r_valid;
    assign err   = r_err;
    assign Qx    = r_qx;
    assign Qy    = r_qy;

endmodule

// File: tb/tb_ec_point_validate_233.sv
// Randomized bench for ec_point_validate_233 against a plain-arithmetic curve model.
module tb_ec_point_validate_233;

    localparam int unsigned W = 233;
    localparam int unsigned D = 8;
    localparam int unsigned L = (W + D - 1) / D;

    localparam logic [W-1:0] CB = 233'h066647EDE6C332C7F8C0923BB58213B333B20E9CE4281FE115F7D8F90AD;
    localparam logic [W-1:0] GX = 233'h0FAC9DFCBAC8313BB2139F1BB755FEF65BC391F8B36F8F8EB7371FD558B;
    localparam logic [W-1:0] GY = 233'h1006A08A41903350678E58528BEBF8A0BEFF867A7CA36716F7E01F81052;
    localparam logic [2*W-1:0] POLY = (466'd1 << 233) | (466'd1 << 74) | 466'd1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] Px;
    logic [W-1:0] Py;
    logic         busy;
    logic         done;
    logic         valid;
    logic [1:0]   err;
    logic [W-1:0] Qx;
    logic [W-1:0] Qy;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ec_point_validate_233 #(.D(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .Px    (Px),
        .Py    (Py),
        .busy  (busy),
        .done  (done),
        .valid (valid),
        .err   (err),
        .Qx    (Qx),
        .Qy    (Qy)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Schoolbook carry-less product followed by polynomial long division by f.
    function automatic logic [W-1:0] gmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = '0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) p ^= ({{W{1'b0}}, a} << i);
        end
        for (int i = 2*W-2; i >= W; i--) begin
            if (p[i]) p ^= (POLY << (i - W));
        end
        return p[W-1:0];
    endfunction

    // a^(2^233 - 2) = a^-1
    function automatic logic [W-1:0] ginv(input logic [W-1:0] a);
        logic [W-1:0] r;
        r = a;
        for (int i = 1; i <= 231; i++) r = gmul(gmul(r, r), a);
        return gmul(r, r);
    endfunction

    function automatic logic [W-1:0] rnd_fe();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r[W-1:0];
    endfunction

    // Solve y^2 + xy = x^3 + x^2 + b via y = x*z, z^2 + z = x + 1 + b/x^2 (half-trace).
    task automatic mk_point(input logic [W-1:0] x, output logic [W-1:0] y, output bit ok);
        logic [W-1:0] c;
        logic [W-1:0] h;
        logic [W-1:0] t;
        c = x ^ W'(1) ^ gmul(CB, ginv(gmul(x, x)));
        h = c;
        t = c;
        for (int i = 1; i <= 116; i++) begin
            t = gmul(t, t);
            t = gmul(t, t);
            h ^= t;
        end
        ok = ((gmul(h, h) ^ h) == c);
        y  = gmul(x, h);
    endtask

    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, output bit ok, output logic [1:0] e);
        logic [W-1:0] lhs;
        logic [W-1:0] rhs;
        if (x == '0) begin
            ok = 1'b0;
            e  = 2'd1;
        end else begin
            lhs = gmul(y, y) ^ gmul(x, y);
            rhs = gmul(gmul(x, x), x) ^ gmul(x, x) ^ CB;
            ok  = (lhs == rhs);
            e   = ok ? 2'd0 : 2'd2;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_busy"},  W'(busy),  '0);
        check_eq({tag, "_done"},  W'(done),  '0);
        check_eq({tag, "_valid"}, W'(valid), '0);
        check_eq({tag, "_err"},   W'(err),   '0);
        check_eq({tag, "_qx"},    Qx,        '0);
        check_eq({tag, "_qy"},    Qy,        '0);
    endtask

    // Issue one request and follow it to done; inj_* are cycles carrying extra
    // (to-be-dropped) start pulses, rst_cyc asserts reset mid-run instead.
    task automatic run_req(input logic [W-1:0] x, input logic [W-1:0] y,
                           input int inj_a, input int inj_b, input int rst_cyc);
        bit         e_ok;
        logic [1:0] e_err;
        int         e_cyc;
        bit         seen;
        bit         busy_ok;
        bit         stop;
        model(x, y, e_ok, e_err);
        e_cyc = (x == '0) ? 3 : int'(2 * L + 5);
        @(negedge clk);
        Px    = x;
        Py    = y;
        start = 1'b1;
        @(posedge clk);
        seen    = 1'b0;
        busy_ok = 1'b1;
        stop    = 1'b0;
        for (int k = 1; k <= 400 && !stop; k++) begin
            @(negedge clk);
            start = (k == inj_a) || (k == inj_b);
            if (start) begin
                Px = '0;
                Py = rnd_fe();
            end
            if (k == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                check_idle_zero("midrst");
                stop = 1'b1;
            end else if (done) begin
                seen = 1'b1;
                stop = 1'b1;
                check_eq("done_cycle", W'(k),       W'(e_cyc));
                check_eq("busy_window", W'(busy_ok), W'(1));
                check_eq("busy_at_done", W'(busy),  '0);
                check_eq("valid",        W'(valid), W'(e_ok));
                check_eq("err",          W'(err),   W'(e_err));
                check_eq("qx",           Qx,        e_ok ? x : '0);
                check_eq("qy",           Qy,        e_ok ? y : '0);
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
        if (!seen && rst_cyc < 0) check_eq("done_timeout", '0, W'(1));
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        bit           ok;
        int           extra;

        rst_n = 1'b0;
        start = 1'b0;
        Px    = '0;
        Py    = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;

        run_req(GX, GY, -1, -1, -1);
        check_eq("gen_valid", W'(valid), W'(1));

        y    = GY;
        y[0] = ~y[0];
        run_req(GX, y, -1, -1, -1);
        check_eq("gen_flip_err", W'(err), W'(2));

        run_req('0, rnd_fe(), 3, -1, -1);
        @(negedge clk);
        start = 1'b0;
        check_eq("xzero_start_at_done_dropped", W'(busy), '0);

        run_req(GX, GY, 10, 64, -1);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done || busy) extra++;
        end
        check_eq("dropped_starts_quiet", W'(extra), '0);

        run_req(GX, GY, -1, -1, 40);
        @(negedge clk);
        @(negedge clk);
        check_idle_zero("held_rst");
        rst_n = 1'b1;
        run_req(GX, GY, -1, -1, -1);

        run_req(GX, GY, -1, -1, -1);
        y    = GY;
        y[0] = ~y[0];
        run_req(GX, y, -1, -1, -1);
        run_req(GX, GY, -1, -1, -1);

        for (int n = 0; n < 6; n++) begin
            ok = 1'b0;
            x  = rnd_fe();
            y  = rnd_fe();
            if (n % 3 != 2) begin
                for (int t = 0; t < 8 && !ok; t++) begin
                    x = rnd_fe();
                    if (x != '0) mk_point(x, y, ok);
                end
                if (n % 3 == 1) y[$urandom_range(W - 1, 0)] ^= 1'b1;
            end
            run_req(x, y, -1, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
